// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and parity codes
// (same encodings as the transmitter so both ends agree on frame format).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Code 3 is reserved and behaves as no parity.
  function automatic logic [1:0] norm_parity(input logic [1:0] p);
    return ((p == PARITY_ODD) || (p == PARITY_EVEN)) ? p : PARITY_NONE;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver for 8N1/8O1/8E1 frames. Optional 3-sample majority voting per bit
// when UART_RX_MAJORITY_VOTE_EN is defined; default build samples once at mid-bit.
//
// state  | meaning
// IDLE   | waiting for a 1->0 edge on the synced line
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit (only if enabled)
// STOP   | sampling stop bit, then publishing byte and flags
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int DATA_BITS       = 8,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 rx_done,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CLOCK_CTR_WIDTH-1:0] LAST     = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] MID      = CLOCK_CTR_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CLOCK_CTR_WIDTH-1:0] CTR_ONE  = CLOCK_CTR_WIDTH'(1);
  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]           IDX_ONE  = IDX_W'(1);

  logic s_in;
  logic bit_val;

  rx_state_e                  state_q, state_d;
  logic [CLOCK_CTR_WIDTH-1:0] ctr_q, ctr_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0]       shift_q, shift_d;
  logic [1:0]                 par_mode_q, par_mode_d;
  logic                       par_bit_q, par_bit_d;
  logic                       s_prev_q, s_prev_d;
  logic [DATA_BITS-1:0]       out_data_q, out_data_d;
  logic                       rx_done_q, rx_done_d;
  logic                       pe_q, pe_d;
  logic                       fe_q, fe_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (s_in)
  );

  assign s_prev_d = s_in;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote over the current and two previous synced samples so the decision stays on the same count.
  logic s_prev2_q, s_prev2_d;
  assign s_prev2_d = s_prev_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_prev2_q <= 1'b1;
    else      s_prev2_q <= s_prev2_d;
  end
  assign bit_val = (s_in & s_prev_q) | (s_in & s_prev2_q) | (s_prev_q & s_prev2_q);
`else
  assign bit_val = s_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_mode_q <= PARITY_NONE;
      par_bit_q  <= 1'b0;
      s_prev_q   <= 1'b1;
      out_data_q <= '0;
      rx_done_q  <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      s_prev_q   <= s_prev_d;
      out_data_q <= out_data_d;
      rx_done_q  <= rx_done_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    out_data_d = out_data_q;
    rx_done_d  = 1'b0;
    pe_d       = pe_q;
    fe_d       = fe_q;
    case (state_q)
      ST_IDLE: begin
        ctr_d = '0;
        idx_d = '0;
        if (s_prev_q && !s_in) begin
          state_d    = ST_START;
          par_mode_d = norm_parity(parity_type);
        end
      end
      ST_START: begin
        if (ctr_q == MID) begin
          ctr_d   = '0;
          state_d = bit_val ? ST_IDLE : ST_DATA;
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      ST_DATA: begin
        if (ctr_q == LAST) begin
          ctr_d          = '0;
          shift_d[idx_q] = bit_val;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (par_mode_q != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      ST_PARITY: begin
        if (ctr_q == LAST) begin
          ctr_d     = '0;
          par_bit_d = bit_val;
          state_d   = ST_STOP;
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      ST_STOP: begin
        if (ctr_q == LAST) begin
          ctr_d      = '0;
          state_d    = ST_IDLE;
          rx_done_d  = 1'b1;
          out_data_d = shift_q;
          fe_d       = ~bit_val;
          case (par_mode_q)
            PARITY_ODD:  pe_d = (par_bit_q != ~^shift_q);
            PARITY_EVEN: pe_d = (par_bit_q != ^shift_q);
            default:     pe_d = 1'b0;
          endcase
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q != ST_IDLE);
  end

  assign out_data      = out_data_q;
  assign rx_done       = rx_done_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;

endmodule
